mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified instruction/data memory between the IF-stage fetch and the
//  MEM-stage load/store. Serialises accesses, holds returned data and drives stall_if/stall_mem.
//  Top level ORs these stalls with the load-use hazard stalls. Data has priority over fetch;
//  a run limit prevents fetch starvation. A watchdog aborts hung accesses.
// PARAMETERS
//  AW         32   address width
//  DW         32   data width
//  MAX_D_RUN  4    max consecutive data grants while if_req is pending
//  TIMEOUT    255  cycles without mem_ready before an access is aborted
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high
//  if_req     in   1   fetch request; level, held until if_done
//  if_addr    in   AW  fetch address
//  if_done    out  1   one-cycle pulse; if_rdata valid in this cycle
//  if_rdata   out  DW  registered fetch data
//  dm_req     in   1   MEM-stage access request; level, held until dm_done
//  dm_we      in   1   1 = store, 0 = load
//  dm_addr    in   AW  data address
//  dm_wdata   in   DW  store data
//  dm_done    out  1   one-cycle pulse; dm_rdata valid in this cycle (loads)
//  dm_rdata   out  DW  registered load data
//  mem_req    out  1   memory access strobe
//  mem_we     out  1   memory write enable
//  mem_addr   out  AW  memory address
//  mem_wdata  out  DW  memory write data
//  mem_rdata  in   DW  memory read data; valid when mem_ready=1
//  mem_ready  in   1   completes the current access
//  stall_if   out  1   if_req & ~if_done (combinational)
//  stall_mem  out  1   dm_req & ~dm_done (combinational)
//  bus_err    out  1   sticky timeout flag
// BEHAVIOUR
//  Reset (async): state IDLE. mem_req, mem_we, mem_addr, mem_wdata, if_done, dm_done,
//   if_rdata, dm_rdata, bus_err, run counter and timeout counter are all 0.
//   Stalls are combinational: they follow the request inputs and the (now 0) done flags.
//  FSM has states IDLE, GNT_I and GNT_D.
//  - IDLE:
//    - Eligible request = req=1 and its own done=0 this cycle (no regrant in the done cycle).
//    - If dm eligible and (if not eligible or run<MAX_D_RUN): go to GNT_D.
//    - Else if if eligible: go to GNT_I. Else stay in IDLE.
//    - On the grant edge, latch addr/we/wdata into the mem_* registers.
//  - GNT_x:
//    - mem_req=1 with all mem_* outputs stable until mem_ready.
//    - On a mem_ready cycle: x_rdata<=mem_rdata (loads/fetch only), x_done<=1, go to IDLE.
//  - Latency: req seen in cycle N -> mem_req in N+1 -> with ready in N+1, done in N+2.
//    Minimum spacing between grants is 2 cycles.
//  - Run counter (saturating at MAX_D_RUN):
//    - +1 on a GNT_D grant while if_req=1.
//    - Cleared on a GNT_I grant, or on a GNT_D grant with if_req=0.
//  - Stores: dm_rdata holds its previous value; dm_done still pulses.
//  - mem_ready in IDLE is ignored. mem_we=0 in GNT_I.
//  - Timeout counter:
//    - Counts GNT_x cycles with mem_ready=0; cleared on grant.
//    - When it reaches TIMEOUT: bus_err<=1 (cleared only by reset), x_rdata<=0, x_done<=1,
//      go to IDLE, mem_req drops.
//  - Requester drops req mid-access (protocol violation, e.g. wrong-path fetch):
//    the access completes and done still pulses.
//  - Reset mid-access: mem_req drops immediately and any pending done is lost.
// TESTING
//  1. Fetch only, ready same cycle as mem_req, rdata=0x00500093
//     -> if_done 2 cycles after if_req; if_rdata=0x00500093; stall_if=1 for 2 cycles.
//  2. if_req and dm_req (load, addr 0x100) together, ready after 3 cycles
//     -> GNT_D first; dm_done; then GNT_I; if_done; mem_we=0 throughout.
//  3. dm_req held through 6 back-to-back accesses (MAX_D_RUN=4) with if_req pending
//     -> grant order D,D,D,D,I,D.
//  4. Store: addr 0x200, wdata 0xDEADBEEF
//     -> mem_we=1, mem_wdata=0xDEADBEEF while mem_req; dm_rdata unchanged; dm_done pulses.
//  5. mem_ready held 0 with TIMEOUT=8
//     -> abort after 8 GNT cycles; bus_err=1 and stays 1; dm_rdata=0; FSM back in IDLE.
//  6. reset asserted while in GNT_I
//     -> mem_req=0 asynchronously; no if_done; after release, the next if_req grants normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port unified instruction/data memory between the IF-stage
//   fetch port and the MEM-stage load/store port. One access is in flight at a
//   time. Data wins over fetch, but only for MAX_D_RUN consecutive grants while
//   a fetch is waiting. A watchdog aborts any access that sees no mem_ready for
//   TIMEOUT cycles and raises a sticky bus_err.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   if_req/if_addr        fetch request (level, held until if_done)
//   if_done/if_rdata      one-cycle completion pulse and registered fetch data
//   dm_req/dm_we/dm_addr/dm_wdata
//                         load/store request (level, held until dm_done)
//   dm_done/dm_rdata      one-cycle completion pulse and registered load data
//   mem_req/mem_we/mem_addr/mem_wdata
//                         memory strobe and access fields (stable until ready)
//   mem_rdata/mem_ready   memory read data and access-complete handshake
//   stall_if/stall_mem    combinational stalls: request pending and not done
//   bus_err               sticky timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_D_RUN = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_done,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          bus_err
);

    localparam int RUN_W = $clog2(MAX_D_RUN + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t           state, state_nxt;
    logic [RUN_W-1:0] run_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             if_elig, dm_elig, abort;

    // A requester is not eligible in its own done cycle: its req is still
    // high there, and regranting would repeat the access it just finished.
    assign if_elig = if_req & ~if_done;
    assign dm_elig = dm_req & ~dm_done;

    // Last silent cycle before the watchdog count would reach TIMEOUT.
    assign abort = (state != IDLE) && !mem_ready && (to_cnt == TO_W'(TIMEOUT - 1));

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dm_elig && (!if_elig || run_cnt < RUN_W'(MAX_D_RUN))) state_nxt = GNT_D;
                else if (if_elig)                                           state_nxt = GNT_I;
            end
            GNT_I, GNT_D: begin
                if (mem_ready || abort) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // mem_req comes straight from the state register, so an async reset
    // drops it immediately.
    always_comb begin
        mem_req   = (state != IDLE);
        stall_if  = if_req & ~if_done;
        stall_mem = dm_req & ~dm_done;
    end

    // ---------------- access datapath ----------------
    // NOTE: every register here is a plain flop (no RAM array), so all of
    // them take the async reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            bus_err   <= 1'b0;
            run_cnt   <= '0;
            to_cnt    <= '0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_nxt == GNT_D) begin
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        to_cnt    <= '0;
                        // Count only data grants that actually held off a fetch.
                        if (!if_req)                             run_cnt <= '0;
                        else if (run_cnt != RUN_W'(MAX_D_RUN))   run_cnt <= run_cnt + 1'b1;
                    end else if (state_nxt == GNT_I) begin
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
                        to_cnt   <= '0;
                        run_cnt  <= '0;
                    end
                end
                GNT_I: begin
                    if (mem_ready) begin
                        if_rdata <= mem_rdata;
                        if_done  <= 1'b1;
                    end else if (abort) begin
                        if_rdata <= '0;
                        if_done  <= 1'b1;
                        bus_err  <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                GNT_D: begin
                    if (mem_ready) begin
                        // Stores leave the last load data visible.
                        if (!mem_we) dm_rdata <= mem_rdata;
                        dm_done <= 1'b1;
                    end else if (abort) begin
                        dm_rdata <= '0;
                        dm_done  <= 1'b1;
                        bus_err  <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
